cdc_gray_src_mchan: RTL and testbench



---
 rtl/cdc_gray_src_mchan.sv | 112 +++++++++++
 tb/tb_cdc_gray_src_mchan.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_gray_src_mchan.sv
// rtl/cdc_gray_src_mchan.sv - multi-channel source half of a gray-pointer async FIFO bank
//
// Ports:
//   src_clk_i     source clock
//   src_rst_i     synchronous active-high reset
//   src_valid_i   per-channel write request
//   src_ready_o   per-channel not-full (forced low during reset)
//   src_data_i    per-channel payload, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   async_data_o  per-channel storage, slot d of channel c at [(c*DEPTH+d)*DATA_WIDTH +: DATA_WIDTH]
//   async_wptr_o  per-channel registered gray write pointer
//   async_rptr_i  per-channel gray read pointer from the destination domain
//   fill_o        per-channel occupancy 0..DEPTH
//   afull_o       per-channel fill_o >= AFULL_THRESH
module cdc_gray_src_mchan #(
    parameter int NUM_CHAN     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int LOG_DEPTH    = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 2**LOG_DEPTH-1,
    localparam int PW          = LOG_DEPTH+1,
    localparam int DEPTH       = 2**LOG_DEPTH
) (
    input  logic                                  src_clk_i,
    input  logic                                  src_rst_i,
    input  logic [NUM_CHAN-1:0]                   src_valid_i,
    output logic [NUM_CHAN-1:0]                   src_ready_o,
    input  logic [NUM_CHAN*DATA_WIDTH-1:0]        src_data_i,
    output logic [NUM_CHAN*DEPTH*DATA_WIDTH-1:0]  async_data_o,
    output logic [NUM_CHAN*PW-1:0]                async_wptr_o,
    input  logic [NUM_CHAN*PW-1:0]                async_rptr_i,
    output logic [NUM_CHAN*PW-1:0]                fill_o,
    output logic [NUM_CHAN-1:0]                   afull_o
);

    // Full when the write pointer is exactly one lap ahead: top two gray bits
    // inverted, the rest equal. Expressed as an XOR mask so LOG_DEPTH=1 works.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW-2);
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("cdc_gray_src_mchan: AFULL_THRESH must be in 1..2**LOG_DEPTH");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("cdc_gray_src_mchan: SYNC_STAGES must be at least 2");
    end

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        logic [PW-1:0]         wb;
        logic [PW-1:0]         wb_nxt;
        logic [PW-1:0]         wg;
        logic [PW-1:0]         sync_q [SYNC_STAGES];
        logic [PW-1:0]         rs;
        logic [PW-1:0]         rb;
        logic [PW-1:0]         fill;
        logic                  full;
        logic                  wr;
        logic [DATA_WIDTH-1:0] mem [DEPTH];

        assign rs     = sync_q[SYNC_STAGES-1];
        assign rb     = gray2bin(rs);
        assign fill   = wb - rb;
        assign full   = (wg == (rs ^ FULL_MASK));
        assign wb_nxt = wb + PW'(1);

        // Ready comes only from registers and reset, never from valid.
        assign src_ready_o[c] = ~full & ~src_rst_i;
        assign wr             = src_valid_i[c] & src_ready_o[c];

        assign async_wptr_o[c*PW +: PW] = wg;
        assign fill_o[c*PW +: PW]       = fill;
        assign afull_o[c]               = (fill >= AFULL_LVL);

        for (genvar d = 0; d < DEPTH; d++) begin : g_slot
            assign async_data_o[(c*DEPTH+d)*DATA_WIDTH +: DATA_WIDTH] = mem[d];
        end

        always_ff @(posedge src_clk_i) begin
            if (src_rst_i) begin
                wb <= '0;
                wg <= '0;
                for (int s = 0; s < SYNC_STAGES; s++) begin
                    sync_q[s] <= '0;
                end
                for (int d = 0; d < DEPTH; d++) begin
                    mem[d] <= '0;
                end
            end else begin
                sync_q[0] <= async_rptr_i[c*PW +: PW];
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_q[s] <= sync_q[s-1];
                end
                if (wr) begin
                    mem[wb[LOG_DEPTH-1:0]] <= src_data_i[c*DATA_WIDTH +: DATA_WIDTH];
                    wb <= wb_nxt;
                    // Gray copy is registered alongside the binary pointer so the
                    // destination never sees a multi-bit transition.
                    wg <= wb_nxt ^ (wb_nxt >> 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cdc_gray_src_mchan.sv
// tb/tb_cdc_gray_src_mchan.sv - self-checking bench for cdc_gray_src_mchan
module tb_cdc_gray_src_mchan;

    localparam int NC = 4;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int PW = 3;

    logic                     clk;
    logic                     rst;
    logic [NC-1:0]            valid;
    logic [NC-1:0]            src_ready_o;
    logic [NC*DW-1:0]         src_data_i;
    logic [NC*DEPTH*DW-1:0]   async_data_o;
    logic [NC*PW-1:0]         async_wptr_o;
    logic [NC*PW-1:0]         async_rptr_i;
    logic [NC*PW-1:0]         fill_o;
    logic [NC-1:0]            afull_o;

    // Stimulus: payload per channel and destination read count per channel.
    logic [DW-1:0] dat [NC];
    int            rd  [NC];

    // Reference model: items written, read counts visible after the sync delay,
    // and what each storage slot should hold.
    int            wcnt [NC];
    int            seen1 [NC];
    int            seen2 [NC];
    logic [DW-1:0] mem_m [NC][DEPTH];
    logic          acc  [NC];

    int n_pass;
    int n_total;

    cdc_gray_src_mchan #(
        .NUM_CHAN(NC), .DATA_WIDTH(DW), .LOG_DEPTH(2),
        .SYNC_STAGES(2), .AFULL_THRESH(3)
    ) dut (
        .src_clk_i    (clk),
        .src_rst_i    (rst),
        .src_valid_i  (valid),
        .src_ready_o  (src_ready_o),
        .src_data_i   (src_data_i),
        .async_data_o (async_data_o),
        .async_wptr_o (async_wptr_o),
        .async_rptr_i (async_rptr_i),
        .fill_o       (fill_o),
        .afull_o      (afull_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] gray(input int v);
        logic [PW-1:0] b;
        b = PW'(v % 8);
        return b ^ (b >> 1);
    endfunction

    always_comb begin
        src_data_i   = '0;
        async_rptr_i = '0;
        for (int c = 0; c < NC; c++) begin
            src_data_i[c*DW +: DW]   = dat[c];
            async_rptr_i[c*PW +: PW] = gray(rd[c]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock edge: advance the model with the inputs that were set up
    // before the edge, then settle 1 ns past the edge.
    task automatic tick();
        @(posedge clk);
        for (int c = 0; c < NC; c++) begin
            acc[c] = 1'b0;
            if (rst) begin
                wcnt[c]  = 0;
                seen1[c] = 0;
                seen2[c] = 0;
                for (int d = 0; d < DEPTH; d++) mem_m[c][d] = '0;
            end else begin
                if (valid[c] && (wcnt[c] - seen2[c]) < DEPTH) begin
                    mem_m[c][wcnt[c] % DEPTH] = dat[c];
                    wcnt[c]++;
                    acc[c] = 1'b1;
                end
                seen2[c] = seen1[c];
                seen1[c] = rd[c];
            end
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        int f;
        for (int c = 0; c < NC; c++) begin
            f = wcnt[c] - seen2[c];
            chk($sformatf("%s fill[%0d]", tag, c), 32'(fill_o[c*PW +: PW]), 32'(f));
            chk($sformatf("%s ready[%0d]", tag, c), 32'(src_ready_o[c]), 32'(!rst && f < DEPTH));
            chk($sformatf("%s afull[%0d]", tag, c), 32'(afull_o[c]), 32'(f >= 3));
            chk($sformatf("%s wptr[%0d]", tag, c), 32'(async_wptr_o[c*PW +: PW]), 32'(gray(wcnt[c])));
            for (int d = 0; d < DEPTH; d++) begin
                chk($sformatf("%s slot[%0d][%0d]", tag, c, d),
                    async_data_o[(c*DEPTH+d)*DW +: DW], mem_m[c][d]);
            end
        end
    endtask

    logic [PW-1:0] exp_w [4];
    logic [DW-1:0] hold_dat [NC];
    logic          pending [NC];

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_w   = '{3'b001, 3'b011, 3'b010, 3'b110};
        rst     = 1'b1;
        valid   = '0;
        for (int c = 0; c < NC; c++) begin
            dat[c] = '0; rd[c] = 0; wcnt[c] = 0; seen1[c] = 0; seen2[c] = 0;
            pending[c] = 1'b0; hold_dat[c] = '0;
            for (int d = 0; d < DEPTH; d++) mem_m[c][d] = '0;
        end

        // Reset, with a write attempt that must be dropped.
        valid[0] = 1'b1;
        dat[0]   = 32'hFF;
        tick();
        chk("ready during reset", 32'(src_ready_o), 32'h0);
        tick();
        rst   = 1'b0;
        valid = '0;
        #1;
        chk("reset ready", 32'(src_ready_o), 32'hF);
        chk("reset wptr", 32'(async_wptr_o), 32'h0);
        chk("reset fill", 32'(fill_o), 32'h0);
        chk("reset afull", 32'(afull_o), 32'h0);
        chk("reset data zero", 32'(async_data_o == '0), 32'h1);
        check_all("reset");

        // Fill channel 0 to full.
        valid[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dat[0] = 32'hA0 + 32'(k);
            tick();
            chk($sformatf("fill wptr step %0d", k), 32'(async_wptr_o[0 +: PW]), 32'(exp_w[k]));
            if (k == 2) chk("afull after 3rd", 32'(afull_o[0]), 32'h1);
            check_all("fill");
        end
        valid[0] = 1'b0;
        chk("full ready0", 32'(src_ready_o[0]), 32'h0);
        chk("full fill0", 32'(fill_o[0 +: PW]), 32'h4);
        for (int d = 0; d < DEPTH; d++)
            chk($sformatf("full slot %0d", d), async_data_o[d*DW +: DW], 32'hA0 + 32'(d));

        // Release one slot from full.
        rd[0] = 1;
        tick();
        chk("release ready0 after 1", 32'(src_ready_o[0]), 32'h0);
        tick();
        chk("release ready0 after 2", 32'(src_ready_o[0]), 32'h1);
        chk("release fill0", 32'(fill_o[0 +: PW]), 32'h3);
        chk("release afull0", 32'(afull_o[0]), 32'h1);
        check_all("release");
        valid[0] = 1'b1;
        dat[0]   = 32'hA4;
        tick();
        valid[0] = 1'b0;
        chk("release wptr0", 32'(async_wptr_o[0 +: PW]), 32'h7);
        check_all("release write");

        // Channel 2 streams across the pointer wrap.
        valid[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            dat[2] = 32'(k);
            rd[2]  = wcnt[2];
            tick();
            chk($sformatf("wrap ready2 %0d", k), 32'(src_ready_o[2]), 32'h1);
            if (wcnt[2] == 7) chk("wrap wptr at 7", 32'(async_wptr_o[2*PW +: PW]), 32'h4);
            if (wcnt[2] == 8) chk("wrap wptr at 8", 32'(async_wptr_o[2*PW +: PW]), 32'h0);
            check_all("wrap");
        end
        valid[2] = 1'b0;
        chk("wrap slot0", async_data_o[(2*DEPTH)*DW +: DW], 32'h08);

        // Reset, then all channels write together.
        rst = 1'b1;
        for (int c = 0; c < NC; c++) rd[c] = 0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_all("reset2");
        valid = 4'hF;
        for (int c = 0; c < NC; c++) dat[c] = 32'h100 * 32'(c + 1) + 32'h5A;
        tick();
        valid = '0;
        for (int c = 0; c < NC; c++)
            chk($sformatf("concurrent fill[%0d]", c), 32'(fill_o[c*PW +: PW]), 32'h1);
        check_all("concurrent");
        rd[1] = 1;
        tick();
        valid[1] = 1'b1;
        dat[1]   = 32'h1B1B;
        tick();
        valid[1] = 1'b0;
        chk("write+read fill1", 32'(fill_o[1*PW +: PW]), 32'h1);
        check_all("write+read");

        // Mid-operation reset on channel 3.
        valid[3] = 1'b1;
        dat[3] = 32'h3331; tick();
        dat[3] = 32'h3332; tick();
        valid[3] = 1'b0;
        chk("midop fill3 before", 32'(fill_o[3*PW +: PW]), 32'h3);
        rst = 1'b1;
        for (int c = 0; c < NC; c++) rd[c] = 0;
        tick();
        rst = 1'b0;
        #1;
        chk("midop wptr3", 32'(async_wptr_o[3*PW +: PW]), 32'h0);
        chk("midop fill3", 32'(fill_o[3*PW +: PW]), 32'h0);
        chk("midop ready3", 32'(src_ready_o[3]), 32'h1);
        chk("midop slot3_0", async_data_o[(3*DEPTH)*DW +: DW], 32'h0);
        check_all("midop");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NC; c++) begin
                if (!pending[c]) begin
                    valid[c] = 1'($urandom_range(0, 1));
                    dat[c]   = $urandom;
                end
                if (rd[c] < wcnt[c] && $urandom_range(0, 2) == 0) rd[c]++;
                hold_dat[c] = dat[c];
            end
            tick();
            for (int c = 0; c < NC; c++) begin
                pending[c] = valid[c] && !acc[c];
                if (pending[c] && dat[c] !== hold_dat[c])
                    $error("FAIL protocol hold ch%0d: observed %0h expected %0h", c, dat[c], hold_dat[c]);
            end
            check_all("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
